// File: rtl/cache_slave_responder_if.sv
// cachepkg: command encoding shared by the responder and its masters.
// cache_slave_responder_if: the 4-phase request/valid handshake plus the
// command and the evict qualifier.
//   operation : command from master (READ / WRITE, anything else is NOP)
//   request   : master 4-phase request
//   valid     : responder acknowledge / response valid
//   evict     : response carries a displaced line on addr/data
// The shared addr/data buses are bidirectional and stay as plain inout
// ports on the responder, so they are not carried here.
package cachepkg;
  typedef enum logic [1:0] {
    NOP   = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } inst_t;
endpackage

interface cache_slave_responder_if;
  cachepkg::inst_t operation;
  logic            request;
  logic            valid;
  logic            evict;

  modport master (
    output operation,
    output request,
    input  valid,
    input  evict
  );

  modport slave (
    input  operation,
    input  request,
    output valid,
    output evict
  );
endinterface

// File: rtl/cache_slave_responder.sv
// cache_slave_responder: direct-mapped cache line store answering a master
// over a 4-phase request/valid handshake with a fixed response latency.
//
// Ports:
//   clock : rising-edge clock for all sequential logic
//   reset : asynchronous active-low reset
//   bus   : cache_slave_responder_if.slave (operation, request, valid, evict)
//   addr  : inout, request address; driven here only in an evict response
//   data  : inout, write data; driven here only in a READ or evict response
//
// Optional feature macro: CACHE_SLAVE_EVICT_EN. When defined, a WRITE that
// displaces a valid line with a different tag returns the old line on
// addr/data with evict high. When undefined, the old line is overwritten
// silently, evict is tied low and addr is never driven.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for request; latches operation/addr/data on accept
// S_BUSY    | latency countdown; operation performed when the count is zero
// S_RESPOND | valid high, response buses held until request drops
module cache_slave_responder #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int INDEXBITS    = 4,
  parameter int LATENCY      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  cache_slave_responder_if.slave        bus,
  inout  wire  [ADDRESSWIDTH-1:0]       addr,
  inout  wire  [DATAWIDTH-1:0]          data
);
  import cachepkg::*;

  localparam int LINES = 2 ** INDEXBITS;
  localparam int TAGW  = ADDRESSWIDTH - INDEXBITS;
  localparam int CNTW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNTW-1:0]         r_cnt;
  inst_t                   r_op;
  logic [ADDRESSWIDTH-1:0] r_req_addr;
  logic [DATAWIDTH-1:0]    r_req_data;
  logic [LINES-1:0]        r_line_vld;
  logic [DATAWIDTH-1:0]    r_line_data [LINES];
  logic [TAGW-1:0]         r_line_tag  [LINES];
  logic                    r_valid;
  logic                    r_drv_data;
  logic [DATAWIDTH-1:0]    r_data_out;
`ifdef CACHE_SLAVE_EVICT_EN
  logic                    r_evict;
  logic                    r_drv_addr;
  logic [ADDRESSWIDTH-1:0] r_addr_out;
`endif

  wire [INDEXBITS-1:0] w_idx   = r_req_addr[INDEXBITS-1:0];
  wire [TAGW-1:0]      w_tag   = r_req_addr[ADDRESSWIDTH-1:INDEXBITS];
  wire                 w_fire  = (r_state == S_BUSY) && (r_cnt == '0);
  wire                 w_tageq = (r_line_tag[w_idx] == w_tag);
  wire                 w_hit   = r_line_vld[w_idx] && w_tageq;
  wire                 w_write = w_fire && (r_op == WRITE);
`ifdef CACHE_SLAVE_EVICT_EN
  wire                 w_conflict = r_line_vld[w_idx] && !w_tageq;
`endif

  // Line contents and tags are not reset; only the valid bits are.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_line_data[w_idx] <= r_req_data;
      r_line_tag[w_idx]  <= w_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= NOP;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_line_vld <= '0;
      r_valid    <= 1'b0;
      r_drv_data <= 1'b0;
      r_data_out <= '0;
`ifdef CACHE_SLAVE_EVICT_EN
      r_evict    <= 1'b0;
      r_drv_addr <= 1'b0;
      r_addr_out <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.request) begin
            r_op       <= bus.operation;
            r_req_addr <= addr;
            r_req_data <= data;
            r_cnt      <= CNT_LOAD;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNTW'(1);
          end else begin
            r_valid <= 1'b1;
            r_state <= S_RESPOND;
            case (r_op)
              READ: begin
                r_drv_data <= 1'b1;
                r_data_out <= w_hit ? r_line_data[w_idx] : '0;
              end
              WRITE: begin
                r_line_vld[w_idx] <= 1'b1;
`ifdef CACHE_SLAVE_EVICT_EN
                // Old line is read here before the storage block overwrites it.
                if (w_conflict) begin
                  r_evict    <= 1'b1;
                  r_drv_addr <= 1'b1;
                  r_addr_out <= {r_line_tag[w_idx], w_idx};
                  r_drv_data <= 1'b1;
                  r_data_out <= r_line_data[w_idx];
                end
`endif
              end
              default: ;
            endcase
          end
        end
        S_RESPOND: begin
          if (!bus.request) begin
            r_valid    <= 1'b0;
            r_drv_data <= 1'b0;
`ifdef CACHE_SLAVE_EVICT_EN
            r_evict    <= 1'b0;
            r_drv_addr <= 1'b0;
`endif
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid = r_valid;
  assign data      = r_drv_data ? r_data_out : 'z;
`ifdef CACHE_SLAVE_EVICT_EN
  assign bus.evict = r_evict;
  assign addr      = r_drv_addr ? r_addr_out : 'z;
`else
  assign bus.evict = 1'b0;
  assign addr      = 'z;
`endif
endmodule

// File: doc/cache_slave_responder.md
CACHE_SLAVE_RESPONDER -- requirements
Module: cache_slave_responder

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of the data bus and of each line.
REQ-002 Parameter ADDRESSWIDTH, default 32, width of the address bus.
REQ-003 Parameter INDEXBITS, default 4, line count = 2**INDEXBITS; index = addr[INDEXBITS-1:0], tag = addr[ADDRESSWIDTH-1:INDEXBITS].
REQ-004 Parameter LATENCY, default 2, range >= 1, cycles from request acceptance to valid.
REQ-005 clock  input  1  single clock for all sequential logic, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 operation  input  cachepkg::inst_t  command; READ and WRITE are decoded, all other values are NOP.
REQ-008 addr  inout  ADDRESSWIDTH  request address from master; driven by this block only during an evict response.
REQ-009 data  inout  DATAWIDTH  write data from master; driven by this block only during a READ or evict response.
REQ-010 request  input  1  master 4-phase request.
REQ-011 valid  output  1  4-phase acknowledge/response valid.
REQ-012 evict  output  1  qualifies a response as an eviction of a displaced line.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and RESPOND.
REQ-014 In IDLE, with request high at a rising edge, the block SHALL latch operation, addr and data, load the latency counter with LATENCY-1, and enter BUSY.
REQ-015 In BUSY, the counter SHALL decrement each cycle; at zero the block SHALL perform the operation, assert valid and enter RESPOND, so valid is first high LATENCY cycles after the accepting edge.
REQ-016 In RESPOND, valid SHALL stay high while request is high; on the first edge with request low, valid and evict SHALL drop and the state SHALL return to IDLE.
REQ-017 A request that is still high in IDLE after a RESPOND SHALL NOT start a transaction until request has been low for at least one edge.
REQ-018 READ hit (line valid, tags equal): data SHALL be driven with the line contents throughout RESPOND; evict = 0.
REQ-019 READ miss: data SHALL be driven with all-zeros; no allocation; evict = 0.
REQ-020 WRITE to an invalid line or a tag-equal line: the line SHALL be written and marked valid; evict = 0; buses not driven.
REQ-021 WRITE to a valid line with a different tag: the line SHALL be overwritten; evict = 1 with valid; addr = {old tag, index}; data = old line data; both held for the whole of RESPOND.
REQ-022 NOP: no storage change; valid handshake completes normally; evict = 0.
REQ-023 Outside the response cases in REQ-018 and REQ-021, addr and data SHALL be high-impedance.
REQ-024 Changes to operation, addr or data after acceptance SHALL be ignored until the next IDLE acceptance.

Reset
REQ-025 While reset is low, the block SHALL force the state to IDLE, valid = 0, evict = 0, the counter to 0, addr and data to high-Z, and clear every line-valid bit, asynchronously and including mid-transaction.
REQ-026 Line data and tag contents need not be cleared at reset.
REQ-027 After reset deasserts, the first acceptance SHALL occur no earlier than the first rising edge with reset high.

Configuration
REQ-028 When macro CACHE_SLAVE_EVICT_EN is defined, the block SHALL behave as in REQ-021.
REQ-029 When CACHE_SLAVE_EVICT_EN is not defined, evict SHALL be tied to 0, addr SHALL never be driven, and a tag-conflicting WRITE SHALL overwrite the line silently, as in REQ-020.

Verification (DATAWIDTH=8, INDEXBITS=4, LATENCY=2, CACHE_SLAVE_EVICT_EN defined)
REQ-030 Scenario 1: WRITE 0x10/0xA5, then READ 0x10 -> on each, valid rises 2 cycles after the accepting edge; READ drives data = 0xA5 with evict = 0.
REQ-031 Scenario 2: after reset, READ 0x20 -> data = 0x00, evict = 0, addr stays Z.
REQ-032 Scenario 3: WRITE 0x10/0xA5, then WRITE 0x110/0x3C -> evict = 1, addr = 0x00000010, data = 0xA5 during RESPOND; a following READ 0x110 returns 0x3C.
REQ-033 Scenario 4: request held high 5 cycles after valid rises -> valid stays high 5 cycles and drops on the edge after request falls; no second transaction without a low request.
REQ-034 Scenario 5: reset pulsed low in BUSY after WRITE 0x10/0xA5 had completed -> valid = 0 and buses Z immediately; a following READ 0x10 returns 0x00.
REQ-035 Scenario 6: NOP at 0x10 after WRITE 0x10/0xA5 -> handshake completes with evict = 0, data Z; a following READ 0x10 returns 0xA5.
